// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets,
// bus FSM encoding and the byte-strobe expansion helper.
package irq_ctrl_pkg;

   localparam logic [1:0] REG_PENDING = 2'd0;
   localparam logic [1:0] REG_MASK    = 2'd1;
   localparam logic [1:0] REG_EDGE    = 2'd2;
   localparam logic [1:0] REG_RAW     = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } bus_state_e;

   function automatic logic [31:0] strobe_mask(input logic [3:0] wstrb);
      logic [31:0] m;
      m = 32'h0000_0000;
      for (int k = 0; k < 4; k++) begin
         if (wstrb[k]) m[8*k +: 8] = 8'hFF;
         else          m[8*k +: 8] = 8'h00;
      end
      return m;
   endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-stage synchroniser for the interrupt source vector, plus a one-cycle
// delayed copy of the synchronised value used for rising-edge detection.
module irq_sync
   import irq_ctrl_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] sync_d
);

   logic [WIDTH-1:0] stage_r [STAGES];
   logic [WIDTH-1:0] sync_d_r;

   // synchroniser chain and edge-detect delay register
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) stage_r[i] <= {WIDTH{1'b0}};
         sync_d_r <= {WIDTH{1'b0}};
      end else begin
         stage_r[0] <= d;
         for (int i = 1; i < STAGES; i++) stage_r[i] <= stage_r[i-1];
         sync_d_r <= stage_r[STAGES-1];
      end
   end

   assign sync   = stage_r[STAGES-1];
   assign sync_d = sync_d_r;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller on the PicoRV32 native bus: latches
// edge/level requests from synchronised sources, masks them and drives irq.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_SRC     = 8,
   parameter int IRQ_BASE    = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               mem_valid,
   input  logic               mem_instr,
   input  logic [3:0]         mem_wstrb,
   input  logic [31:0]        mem_wdata,
   input  logic [31:0]        mem_addr,
   output logic               mem_ready,
   output logic [31:0]        mem_rdata,
   input  logic [NUM_SRC-1:0] src_in,
   output logic [31:0]        irq,
   input  logic [31:0]        eoi
);

   bus_state_e         state_r, state_nxt_s;
   logic               access_s, wr_s, ready_r;
   logic [NUM_SRC-1:0] sync_s, sync_d_s, eoi_s, wr_bits_s, w1c_s;
   logic [NUM_SRC-1:0] pending_r, mask_r, edge_r;
   logic [NUM_SRC-1:0] pending_nxt_s, mask_nxt_s, edge_nxt_s;
   logic [31:0]        bm_s, rd_s, irq_vec_s, irq_r, rdata_r;
   logic               unused_s;

   irq_sync #(.WIDTH(NUM_SRC), .STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .d      (src_in),
      .sync   (sync_s),
      .sync_d (sync_d_s)
   );

   // bus FSM next state; an access is accepted only from IDLE
   always_comb begin
      state_nxt_s = ST_IDLE;
      access_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (mem_valid && enable && !mem_instr) begin
               state_nxt_s = ST_ACK;
               access_s    = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
               access_s    = 1'b0;
            end
         end
         ST_ACK:  state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // register writes, pending update, read mux and irq vector
   always_comb begin
      bm_s       = strobe_mask(mem_wstrb);
      wr_bits_s  = mem_wdata[NUM_SRC-1:0] & bm_s[NUM_SRC-1:0];
      wr_s       = access_s && (mem_wstrb != 4'b0000);
      eoi_s      = eoi[IRQ_BASE +: NUM_SRC];
      mask_nxt_s = mask_r;
      edge_nxt_s = edge_r;
      w1c_s      = {NUM_SRC{1'b0}};
      if (wr_s) begin
         case (mem_addr[3:2])
            REG_PENDING: w1c_s      = wr_bits_s;
            REG_MASK:    mask_nxt_s = (mask_r & ~bm_s[NUM_SRC-1:0]) | wr_bits_s;
            REG_EDGE:    edge_nxt_s = (edge_r & ~bm_s[NUM_SRC-1:0]) | wr_bits_s;
            default:     w1c_s      = {NUM_SRC{1'b0}};
         endcase
      end else begin
         w1c_s = {NUM_SRC{1'b0}};
      end
      // edge bits: a fresh rising edge beats a same-cycle clear
      pending_nxt_s = (edge_r & ((pending_r & ~(w1c_s | eoi_s)) | (sync_s & ~sync_d_s)))
                    | (~edge_r & sync_s);

      rd_s = 32'h0000_0000;
      case (mem_addr[3:2])
         REG_PENDING: rd_s[NUM_SRC-1:0] = pending_r;
         REG_MASK:    rd_s[NUM_SRC-1:0] = mask_r;
         REG_EDGE:    rd_s[NUM_SRC-1:0] = edge_r;
         REG_RAW:     rd_s[NUM_SRC-1:0] = sync_s;
         default:     rd_s = 32'h0000_0000;
      endcase

      irq_vec_s = 32'h0000_0000;
      irq_vec_s[IRQ_BASE +: NUM_SRC] = pending_r & mask_r;
   end

   // state, register file and registered bus/irq outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         pending_r <= {NUM_SRC{1'b0}};
         mask_r    <= {NUM_SRC{1'b0}};
         edge_r    <= {NUM_SRC{1'b0}};
         irq_r     <= 32'h0000_0000;
         ready_r   <= 1'b0;
         rdata_r   <= 32'h0000_0000;
      end else begin
         state_r   <= state_nxt_s;
         pending_r <= pending_nxt_s;
         mask_r    <= mask_nxt_s;
         edge_r    <= edge_nxt_s;
         irq_r     <= irq_vec_s;
         ready_r   <= access_s;
         rdata_r   <= access_s ? rd_s : 32'h0000_0000;
      end
   end

   assign mem_ready = ready_r;
   assign mem_rdata = rdata_r;
   assign irq       = irq_r;
   assign unused_s  = ^{mem_addr, mem_wdata, eoi, bm_s};

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomised traffic,
// every cycle compared against a behavioural reference model.
module tb_irq_ctrl;

   localparam int NUM_SRC  = 8;
   localparam int IRQ_BASE = 3;
   localparam int SS       = 2;
   localparam logic [31:0] SRC_MASK = 32'h0000_00FF;

   logic               clk = 1'b0;
   logic               reset, enable, mem_valid, mem_instr, mem_ready;
   logic [3:0]         mem_wstrb;
   logic [31:0]        mem_wdata, mem_addr, mem_rdata, irq, eoi;
   logic [NUM_SRC-1:0] src_in;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   irq_ctrl #(.NUM_SRC(NUM_SRC), .IRQ_BASE(IRQ_BASE), .SYNC_STAGES(SS)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .mem_valid (mem_valid),
      .mem_instr (mem_instr),
      .mem_wstrb (mem_wstrb),
      .mem_wdata (mem_wdata),
      .mem_addr  (mem_addr),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .src_in    (src_in),
      .irq       (irq),
      .eoi       (eoi)
   );

   // reference model state (values after the most recent clock edge)
   logic [31:0]        m_pend, m_mask, m_edge, m_irq, m_rdata;
   logic [NUM_SRC-1:0] m_sync_d;
   logic               m_ready, m_busy;
   logic [NUM_SRC-1:0] sync_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = 32'd0; m_mask = 32'd0; m_edge = 32'd0; m_irq = 32'd0;
      m_rdata = 32'd0; m_ready = 1'b0; m_busy = 1'b0; m_sync_d = '0;
      sync_q = {};
      repeat (SS) sync_q.push_back('0);
   endtask

   // advance the model across one clock edge using the current inputs
   task automatic model_update();
      logic [31:0]        bm, wd, nxt_pend, nxt_irq, nxt_rdata;
      logic [NUM_SRC-1:0] sync;
      logic               accept, is_wr;
      if (reset) begin
         model_reset();
         return;
      end
      accept = mem_valid && enable && !mem_instr && !m_busy;
      is_wr  = accept && (mem_wstrb != 4'b0000);
      bm = 32'd0;
      for (int k = 0; k < 4; k++) if (mem_wstrb[k]) bm[8*k +: 8] = 8'hFF;
      wd = mem_wdata & bm & SRC_MASK;
      sync = sync_q[0];

      nxt_pend = 32'd0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (m_edge[i]) begin
            if (sync[i] && !m_sync_d[i])
               nxt_pend[i] = 1'b1;
            else if ((is_wr && mem_addr[3:2] == 2'd0 && wd[i]) || eoi[IRQ_BASE+i])
               nxt_pend[i] = 1'b0;
            else
               nxt_pend[i] = m_pend[i];
         end else begin
            nxt_pend[i] = sync[i];
         end
      end
      nxt_irq = (m_pend & m_mask) << IRQ_BASE;

      nxt_rdata = 32'd0;
      if (accept) begin
         case (mem_addr[3:2])
            2'd0: nxt_rdata = m_pend;
            2'd1: nxt_rdata = m_mask;
            2'd2: nxt_rdata = m_edge;
            default: nxt_rdata = 32'(sync);
         endcase
      end
      if (is_wr && mem_addr[3:2] == 2'd1) m_mask = (m_mask & ~bm) | wd;
      if (is_wr && mem_addr[3:2] == 2'd2) m_edge = (m_edge & ~bm) | wd;

      m_pend   = nxt_pend;
      m_irq    = nxt_irq;
      m_rdata  = nxt_rdata;
      m_ready  = accept;
      m_busy   = accept;
      m_sync_d = sync;
      sync_q.push_back(src_in);
      void'(sync_q.pop_front());
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      @(negedge clk);
      check_eq("ready", 32'(mem_ready), 32'(m_ready));
      check_eq("rdata", mem_rdata, m_rdata);
      check_eq("irq", irq, m_irq);
   endtask

   task automatic bus_access(input logic [1:0] rg, input logic [3:0] strb,
                             input logic [31:0] data, output logic [31:0] rd);
      mem_addr  = {28'h0, rg, 2'b00};
      mem_wstrb = strb;
      mem_wdata = data;
      mem_instr = 1'b0;
      enable    = 1'b1;
      mem_valid = 1'b1;
      tick();
      rd = mem_rdata;
      check_eq("ack", 32'(mem_ready), 32'd1);
      mem_valid = 1'b0;
      enable    = 1'b0;
      mem_wstrb = 4'b0000;
      tick();
      check_eq("ack_one_cycle", 32'(mem_ready), 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      int          n;
      reset = 1'b1; enable = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
      mem_wstrb = 4'b0000; mem_wdata = 32'd0; mem_addr = 32'd0;
      src_in = '0; eoi = 32'd0;
      model_reset();

      // reset held while an access is presented: no ready
      tick();
      enable = 1'b1; mem_valid = 1'b1;
      tick();
      check_eq("rst_access", 32'(mem_ready), 32'd0);
      reset = 1'b0; enable = 1'b0; mem_valid = 1'b0;
      tick();

      for (int r = 0; r < 4; r++) begin
         bus_access(2'(r), 4'b0000, 32'd0, rd);
         check_eq("rst_reg", rd, 32'd0);
      end
      check_eq("rst_irq", irq, 32'd0);

      // edge source 0
      bus_access(2'd1, 4'b1111, 32'h1, rd);
      bus_access(2'd2, 4'b1111, 32'h1, rd);
      src_in[0] = 1'b1; tick(); n = 1; src_in[0] = 1'b0;
      while (irq[IRQ_BASE] !== 1'b1 && n < 10) begin tick(); n++; end
      check_eq("edge_latency", 32'(n), 32'(SS + 2));
      repeat (3) tick();
      check_eq("edge_hold", 32'(irq[IRQ_BASE]), 32'd1);
      bus_access(2'd0, 4'b0000, 32'd0, rd);
      check_eq("pending_edge", rd, 32'h1);

      // W1C clears irq two edges after the write is taken
      mem_addr = 32'h0; mem_wstrb = 4'b1111; mem_wdata = 32'h1;
      enable = 1'b1; mem_valid = 1'b1;
      tick();
      check_eq("w1c_edge1", 32'(irq[IRQ_BASE]), 32'd1);
      mem_valid = 1'b0; enable = 1'b0; mem_wstrb = 4'b0000;
      tick();
      check_eq("w1c_edge2", 32'(irq[IRQ_BASE]), 32'd0);

      // same again, cleared with eoi
      src_in[0] = 1'b1; tick(); src_in[0] = 1'b0;
      repeat (SS + 2) tick();
      check_eq("eoi_pre", 32'(irq[IRQ_BASE]), 32'd1);
      eoi[IRQ_BASE] = 1'b1; tick(); eoi = 32'd0;
      check_eq("eoi_edge1", 32'(irq[IRQ_BASE]), 32'd1);
      tick();
      check_eq("eoi_edge2", 32'(irq[IRQ_BASE]), 32'd0);

      // level source 1
      bus_access(2'd1, 4'b1111, 32'h2, rd);
      src_in[1] = 1'b1;
      repeat (SS + 2) tick();
      check_eq("level_on", 32'(irq[IRQ_BASE+1]), 32'd1);
      bus_access(2'd0, 4'b1111, 32'h2, rd);
      repeat (2) tick();
      check_eq("level_w1c", 32'(irq[IRQ_BASE+1]), 32'd1);
      src_in[1] = 1'b0; n = 0;
      while (irq[IRQ_BASE+1] !== 1'b0 && n < 10) begin tick(); n++; end
      check_eq("level_off", 32'(n), 32'(SS + 2));

      // rising edge on source 2 coincides with W1C of bit 2
      bus_access(2'd2, 4'b1111, 32'h5, rd);
      bus_access(2'd1, 4'b1111, 32'h4, rd);
      src_in[2] = 1'b1;
      repeat (SS) tick();
      bus_access(2'd0, 4'b1111, 32'h4, rd);
      bus_access(2'd0, 4'b0000, 32'd0, rd);
      check_eq("set_wins", rd & 32'h4, 32'h4);
      src_in[2] = 1'b0;

      // byte strobes and bits beyond NUM_SRC
      bus_access(2'd1, 4'b1111, 32'd0, rd);
      bus_access(2'd1, 4'b0010, 32'hFFFF_FFFF, rd);
      bus_access(2'd1, 4'b0000, 32'd0, rd);
      check_eq("strobe_hi", rd, 32'd0);
      bus_access(2'd1, 4'b0001, 32'hFFFF_FFFF, rd);
      bus_access(2'd1, 4'b0000, 32'd0, rd);
      check_eq("strobe_lo", rd, 32'h0000_00FF);

      // RAW reflects synchronised inputs and ignores writes
      src_in = 8'hA5;
      repeat (SS + 1) tick();
      bus_access(2'd3, 4'b1111, 32'hFF, rd);
      bus_access(2'd3, 4'b0000, 32'd0, rd);
      check_eq("raw", rd, 32'hA5);

      // instruction fetches are never acknowledged
      mem_addr = 32'h0; mem_instr = 1'b1; enable = 1'b1; mem_valid = 1'b1;
      repeat (4) begin
         tick();
         check_eq("fetch_no_ready", 32'(mem_ready), 32'd0);
      end
      mem_instr = 1'b0; enable = 1'b0; mem_valid = 1'b0;
      tick();

      // randomised traffic against the model
      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 3) == 0) src_in = NUM_SRC'($urandom);
         eoi = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
         case ($urandom_range(0, 9))
            0, 1, 2: tick();
            3: begin
               mem_addr = {28'h0, 2'($urandom), 2'b00};
               mem_instr = 1'b1; enable = 1'b1; mem_valid = 1'b1;
               tick();
               mem_instr = 1'b0; enable = 1'b0; mem_valid = 1'b0;
               tick();
            end
            4: if ($urandom_range(0, 19) == 0) begin
                  reset = 1'b1; tick(); reset = 1'b0; tick();
               end else begin
                  tick();
               end
            default: bus_access(2'($urandom),
                                ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom),
                                $urandom, rd);
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller on the PicoRV32 native memory bus. It synchronises up to NUM_SRC external interrupt sources, latches edge- or level-type requests, and masks them. It drives the CPU `irq` vector and consumes the CPU `eoi` vector. It sits directly upstream of the CPU interrupt inputs. It is selected by one `enables` bit from the address decoder, and its read data and ready signals are OR-ed into the shared bus like every other peripheral.

## Interface
- NUM_SRC, 8: number of external sources (1..29).
- IRQ_BASE, 3: CPU irq bit driven by source 0. Bits 0..2 stay reserved for CPU-internal causes.
- SYNC_STAGES, 2: flip-flop stages on each source input (2..3).
- clk  in  1  system clock (100 MHz domain).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  chip select from the address decoder.
- mem_valid  in  1  bus request valid.
- mem_instr  in  1  instruction fetch flag. Fetches are never acknowledged.
- mem_wstrb  in  4  byte write strobes. All zeros means a read.
- mem_wdata  in  32  write data.
- mem_addr  in  32  byte address. Only [3:2] are decoded.
- mem_ready  out  1  one-cycle acknowledge.
- mem_rdata  out  32  read data. Zero whenever mem_ready is low.
- src_in  in  NUM_SRC  asynchronous interrupt sources, active-high.
- irq  out  32  interrupt vector to the CPU.
- eoi  in  32  end-of-interrupt vector from the CPU.

## Operation
- Register map, word offsets in mem_addr[3:2]:
  - 0x0 PENDING: read, write-1-to-clear.
  - 0x1 MASK: read/write. 1 means enabled.
  - 0x2 EDGE: read/write. 1 means rising-edge type, 0 means level type.
  - 0x3 RAW: read-only. Returns the synchronised src_in.
- Bits at or above NUM_SRC read 0 and ignore writes.
- Source path: `src_in[i]` passes through a SYNC_STAGES synchroniser to `sync[i]`. `sync_d[i]` is `sync[i]` delayed one cycle.
- Edge source: `pending[i]` sets on `sync[i] & ~sync_d[i]`. It clears on a PENDING write with `wdata[i]=1` or on `eoi[IRQ_BASE+i]=1`.
- Level source: `pending[i] = sync[i]`, registered. W1C and eoi have no effect on it.
- Set/clear priority: if a set and a clear hit the same bit in the same cycle, set wins.
- Output: `irq[IRQ_BASE+i] = pending[i] & mask[i]`, registered. All other irq bits are 0.
- Clearing a MASK bit hides the request but does not clear `pending`.
- Changing EDGE does not clear `pending`. The new type applies from the next cycle.
- Byte strobes: writes apply per byte lane, so `wstrb[k]` gates bits `[8k+7:8k]`. A write to RAW is acknowledged and has no effect.
- Bus accesses with `mem_instr=1` are not acknowledged.

## Timing
- Bus FSM has two states, IDLE and ACK.
  - IDLE to ACK when `mem_valid & enable & ~mem_instr`.
  - In ACK, `mem_ready=1` for exactly one cycle and mem_rdata is valid, then the FSM returns to IDLE.
  - A request still asserted in the cycle after ACK is treated as a new access. The CPU drops mem_valid after ready, so this does not occur in normal operation.
- Register writes take effect at the clock edge that enters ACK.
- Read data is sampled in IDLE with the state as of that edge and is registered.
- Latency from a src_in rising edge to irq high is SYNC_STAGES + 2 cycles, with the mask already set.
- Latency from a W1C write or eoi to irq low is 2 cycles.
- Reset values: pending=0, mask=0, edge=0, synchroniser=0, sync_d=0, irq=0, mem_ready=0, mem_rdata=0, FSM=IDLE.
- Reset asserted during an access: the FSM returns to IDLE and no ready is issued for that access.

## Structure
- Package `irq_ctrl_pkg` holds the register offset constants (PENDING, MASK, EDGE, RAW) and the FSM state encoding.
- Sub-module `irq_sync`: a parameterised SYNC_STAGES synchroniser plus the delayed copy for edge detection, instantiated once over the NUM_SRC-wide vector.
- Top-level change: `irq_ctrl` takes a free `enables` bit, and its mem_rdata and mem_ready join the OR-trees.

## Test plan
- Reset, then read all four registers: each returns 0x0 with mem_ready high for exactly one cycle. irq = 0.
- MASK=0x01, EDGE=0x01, pulse `src_in[0]` high for 1 cycle: `irq[3]` rises SYNC_STAGES+2 cycles later and stays high. PENDING reads 0x01.
- From the previous state, write PENDING=0x01: `irq[3]` falls 2 cycles later. Repeat with `eoi[3]=1` instead of the write: same result.
- Level source 1, MASK=0x02: hold `src_in[1]` high and `irq[4]` follows it. A W1C to PENDING=0x02 has no effect. Drop `src_in[1]` and `irq[4]` clears 2+SYNC_STAGES cycles later.
- Edge on source 2 landing in the same cycle as W1C of bit 2: PENDING bit 2 remains 1.
- Write MASK=0xFFFF_FFFF with wstrb=0b0001: MASK reads 0x0000_00FF for NUM_SRC=8. A fetch access (`mem_instr=1`) never gets mem_ready.
